divider_unit: RTL
=================

// Module: divider_unit
// PURPOSE
//  Multi-cycle RV32M divide/remainder responder beside the combinational ALU. Takes operands and an
//  op code under a start/done handshake, iterates one quotient bit per clock and returns a 32-bit
//  result. The core stalls on busy and captures result on done.
// PARAMETERS
//  XLEN     32   operand/result width; only 32 is supported
//  CNT_W    5    iteration counter width, log2(XLEN)
// PORTS
//  clk      in   1     rising-edge clock
//  reset    in   1     synchronous, active-high reset
//  start    in   1     request; sampled only in IDLE
//  div_op   in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  src_A    in   32    dividend
//  src_B    in   32    divisor
//  flush    in   1     abort the operation in flight (pipeline kill)
//  busy     out  1     state != IDLE
//  done     out  1     one-cycle pulse; result valid in the same cycle
//  result   out  32    quotient or remainder; registered, holds until the next done
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is synchronous and active-high.
//  - reset high at a clock edge: state=IDLE, busy=0, done=0, result=0, counter=0.
//  - reset overrides start and flush. Reset mid-operation discards the operation; no done.
//  States: IDLE -> CALC -> DONE -> IDLE. IDLE -> DONE is the special-case path.
//  - IDLE: when start=1 at edge T, latch op, operand signs, |A| and |B|.
//      |x| = two's-complement negate when the op is signed and x[31]=1.
//      divisor==0 or (signed op, A=8000_0000, B=FFFF_FFFF): go to DONE with the special result.
//      otherwise: go to CALC, counter=31.
//  - CALC: restoring step each cycle: rem={rem[30:0],quo[31]}; quo<<=1; trial = rem - divisor
//      (33-bit); if no borrow, rem=trial and quo[0]=1. 32 cycles, counter 31 down to 0.
//      At counter=0, go to DONE.
//  - DONE: done=1 for exactly one cycle; result register loaded on the edge entering DONE;
//      next state IDLE. The next start is accepted at the earliest in the cycle after DONE.
//  Latency, counting the cycle after the start edge T as T+1:
//      normal: done in cycle T+33; busy=1 in cycles T+1..T+33.
//      special case: done in cycle T+1.
//  Sign fix-up:
//      quotient is negated when the signed op has operands of differing sign.
//      remainder takes the dividend's sign.
//  Special results:
//      divide by zero: DIV/DIVU = FFFF_FFFF; REM/REMU = src_A.
//      signed overflow: DIV = 8000_0000; REM = 0.
//  Boundaries:
//      start while busy: ignored, with no side effects.
//      flush in CALC or DONE: state=IDLE at the next edge; done suppressed; result unchanged.
//      flush in IDLE together with start: flush wins; the request is dropped.
//      src_A, src_B and div_op may change after the start edge; they are used only at that edge.
//      A=0: quotient 0, remainder 0 after the full 32 cycles (no early out).
// STRUCTURE
//  - Shared package holds the div_op encodings (DIV, DIVU, REM, REMU), the state encodings
//    (IDLE, CALC, DONE) and XLEN. It sits with the existing ALU op defines.
//  - No sub-module: one FSM plus the iteration datapath, all in this file.
// TESTING
//  1. DIVU A=100, B=7, start at T -> done=1 only in cycle T+33, result=14; then REMU -> 2.
//  2. DIV A=FFFF_FFF9 (-7), B=2 -> FFFF_FFFD (-3); REM same operands -> FFFF_FFFF (-1).
//  3. DIVU A=1972, B=0 -> done at T+1, result=FFFF_FFFF; REMU -> 1972 (0x7B4).
//  4. DIV A=8000_0000, B=FFFF_FFFF -> done at T+1, result=8000_0000; REM same operands -> 0.
//  5. Start DIVU 1000/3, re-pulse start at T+5 with 9/3, assert flush at T+10
//     -> busy=0 at T+11, no done, result unchanged.
//     Then a new start 31011/31011 -> result=1.
//  6. Start DIV 1972/1121, assert reset at T+20 -> next cycle busy=0, done=0, result=0.
//     A later start 1972/1121 completes -> result=1.

Source files
------------

// File: rtl/divider_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_unit_pkg
//  Description : Shared definitions for the RV32M divide/remainder unit:
//                operand width, iteration counter width, div_op encodings
//                and FSM state encodings. Lives next to the ALU op defines.
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_unit_pkg;

  localparam int XLEN  = 32;  // operand/result width; only 32 is supported
  localparam int CNT_W = 5;   // log2(XLEN)

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  // Bit 0 of the op code selects unsigned, bit 1 selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_unit.sv
`default_nettype none
// ============================================================================
//  Module      : divider_unit
//  Description : Multi-cycle RV32M DIV/DIVU/REM/REMU unit. Restoring
//                division on operand magnitudes, one quotient bit per clock,
//                with sign fix-up applied when the result is written.
//                Divide-by-zero and signed overflow bypass the iteration.
//  Ports       : clk     - rising-edge clock
//                reset   - synchronous active-high reset
//                start   - request, sampled only while idle
//                div_op  - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//                src_A   - dividend
//                src_B   - divisor
//                flush   - abort operation in flight / drop request
//                busy    - unit not idle
//                done    - one-cycle pulse, result valid in same cycle
//                result  - registered quotient or remainder
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_unit
  import divider_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] src_A,
  input  logic [XLEN-1:0] src_B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_ALL_ONES = {XLEN{1'b1}};

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   rem_q, rem_d;     // partial remainder
  logic [XLEN-1:0]   dvsr_q, dvsr_d;   // divisor magnitude
  logic              is_rem_q, is_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand conditioning for the IDLE capture.
  logic            w_signed;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_div_zero, w_overflow;
  logic [XLEN-1:0] w_special;

  // One restoring step on the current registers.
  logic [XLEN:0]   w_rem_shift, w_trial;
  logic [XLEN-1:0] w_step_quo, w_step_rem;
  logic [XLEN-1:0] w_fin_quo, w_fin_rem;

  always_comb begin
    w_signed   = op_is_signed(div_op);
    w_abs_a    = (w_signed && src_A[XLEN-1]) ? -src_A : src_A;
    w_abs_b    = (w_signed && src_B[XLEN-1]) ? -src_B : src_B;
    w_div_zero = (src_B == '0);
    w_overflow = w_signed && (src_A == C_INT_MIN) && (src_B == C_ALL_ONES);
    if (w_div_zero) begin
      w_special = op_is_rem(div_op) ? src_A : C_ALL_ONES;
    end else begin
      w_special = op_is_rem(div_op) ? '0 : C_INT_MIN;
    end

    // rem < divisor always holds, so the shifted value fits in XLEN+1 bits
    // and the trial subtraction's top bit is a clean borrow flag.
    w_rem_shift = {rem_q, quo_q[XLEN-1]};
    w_trial     = w_rem_shift - {1'b0, dvsr_q};
    if (!w_trial[XLEN]) begin
      w_step_rem = w_trial[XLEN-1:0];
      w_step_quo = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      w_step_rem = w_rem_shift[XLEN-1:0];
      w_step_quo = {quo_q[XLEN-2:0], 1'b0};
    end
    w_fin_quo = neg_quo_q ? -w_step_quo : w_step_quo;
    w_fin_rem = neg_rem_q ? -w_step_rem : w_step_rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        // A flush in the same cycle as start kills the request.
        if (start && !flush) begin
          is_rem_d  = op_is_rem(div_op);
          neg_quo_d = w_signed && (src_A[XLEN-1] ^ src_B[XLEN-1]);
          neg_rem_d = w_signed && src_A[XLEN-1];
          quo_d     = w_abs_a;
          rem_d     = '0;
          dvsr_d    = w_abs_b;
          if (w_div_zero || w_overflow) begin
            result_d = w_special;
            state_d  = ST_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          quo_d = w_step_quo;
          rem_d = w_step_rem;
          if (cnt_q == '0) begin
            result_d = is_rem_q ? w_fin_rem : w_fin_quo;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  // A flush arriving while in DONE kills the completion pulse.
  assign done   = (state_q == ST_DONE) && !flush;
  assign result = result_q;

endmodule
`default_nettype wire
